hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage processor, sitting beside the ID stage. It detects load-use hazards and branch-operand hazards, resolved in ID, against the EX and MEM stages. It stretches load-use stalls to a configurable memory latency with an internal stall FSM, and issues IF/ID flushes on taken branches. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_perf_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// The decoder that produces id_uses_*/ex_mem_read keys loads on LOAD_OP.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REM_W    = 4;
  localparam logic [5:0]  LOAD_OP  = 6'b100011;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module hazard_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard detection beside ID, with a stall FSM
// that stretches load-use bubbles to LOAD_STALL cycles and a stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_mem_read,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles
);

  function automatic logic reg_match(
    input logic [REG_W-1:0] d,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             use_rs,
    input logic             use_rt
  );
    return (d != REG_W'(REG_ZERO)) &&
           (((d == rs) && use_rs) || ((d == rt) && use_rt));
  endfunction

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             ex_match, mem_match;
  logic             load_use, br_haz;
  logic             stall_raw, stall;

  assign ex_match  = reg_match(ex_dst,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign mem_match = reg_match(mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);

  assign load_use  = ex_mem_read && ex_match;
  assign br_haz    = id_is_branch &&
                     ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));

  // While in STALL the detection terms are irrelevant: the state alone holds the pipe.
  assign stall_raw = (state_q == STALL) || load_use || br_haz;
  assign stall     = stall_raw && !rst;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (load_use && (LOAD_STALL > 1)) begin
          state_d = STALL;
          rem_d   = REM_W'(LOAD_STALL - 1);
        end
      end
      STALL: begin
        if (rem_q == REM_W'(1)) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d   = rem_q - REM_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign pc_stall     = stall;
  assign if_id_stall  = stall;
  assign id_ex_bubble = stall;
  // A stalled branch is re-resolved once the hazard clears, so it never flushes here.
  assign if_id_flush  = id_branch_taken && !stall_raw && !rst;
  assign stall_active = (state_q == STALL) && !rst;

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (perf_clr),
    .en_i    (stall),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL 1/3/4, the last with a
// 4-bit counter) share one stimulus stream; expectations go through a queue.
module tb_hazard_ctrl;

  localparam int REG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, perf_clr;
  logic [REG_W-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic             id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
  logic             ex_reg_write, ex_mem_read, mem_mem_read;

  // Bit 2: LOAD_STALL=1, bit 1: LOAD_STALL=3, bit 0: LOAD_STALL=4.
  logic [2:0]  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, stall_active;
  logic [15:0] cnt1, cnt3;
  logic [3:0]  cnt4;

  hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_mem_read(mem_mem_read), .perf_clr(perf_clr),
    .pc_stall(pc_stall[2]), .if_id_stall(if_id_stall[2]), .id_ex_bubble(id_ex_bubble[2]),
    .if_id_flush(if_id_flush[2]), .stall_active(stall_active[2]), .stall_cycles(cnt1));

  hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL(3), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_mem_read(mem_mem_read), .perf_clr(perf_clr),
    .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]), .id_ex_bubble(id_ex_bubble[1]),
    .if_id_flush(if_id_flush[1]), .stall_active(stall_active[1]), .stall_cycles(cnt3));

  hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL(4), .CNT_W(4)) d4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_mem_read(mem_mem_read), .perf_clr(perf_clr),
    .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]), .id_ex_bubble(id_ex_bubble[0]),
    .if_id_flush(if_id_flush[0]), .stall_active(stall_active[0]), .stall_cycles(cnt4));

  typedef struct packed {
    logic [2:0]  p;
    logic [2:0]  i;
    logic [2:0]  b;
    logic [2:0]  a;
    logic [2:0]  f;
    logic [15:0] c1;
    logic [15:0] c3;
    logic [3:0]  c4;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m1 = '0, m3 = '0;
  logic [3:0]  m4 = '0;

  // Push this cycle's expectation; counters show the value before this edge.
  task automatic push_exp(input logic [2:0] s, input logic [2:0] a, input logic [2:0] f);
    obs_t e;
    e.p = s; e.i = s; e.b = s; e.a = a; e.f = f;
    e.c1 = m1; e.c3 = m3; e.c4 = m4;
    exp_q.push_back(e);
    if (rst || perf_clr) begin
      m1 = '0; m3 = '0; m4 = '0;
    end else begin
      if (s[2] && m1 != 16'hFFFF) m1 = m1 + 16'd1;
      if (s[1] && m3 != 16'hFFFF) m3 = m3 + 16'd1;
      if (s[0] && m4 != 4'hF)     m4 = m4 + 4'd1;
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.p = pc_stall; o.i = if_id_stall; o.b = id_ex_bubble;
    o.a = stall_active; o.f = if_id_flush;
    o.c1 = cnt1; o.c3 = cnt3; o.c4 = cnt4;
    return o;
  endfunction

  task automatic clr_in();
    id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_branch_taken = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_mem_read = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    rst = 1'b1; perf_clr = 1'b0; clr_in();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    id_is_branch = 1'b1; id_branch_taken = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      push_exp(3'b000, 3'b000, 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
    rst = 1'b0; clr_in();
  endtask

  task automatic test_load_use_rt();
    obs_t got, e;
    logic [2:0] s_t [5] = '{3'b111, 3'b011, 3'b011, 3'b001, 3'b000};
    logic [2:0] a_t [5] = '{3'b000, 3'b011, 3'b011, 3'b001, 3'b000};
    for (int k = 0; k < 5; k++) begin
      clr_in();
      if (k == 0) begin
        ex_mem_read = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
      end
      push_exp(s_t[k], a_t[k], 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_use_rt cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_r0_immunity();
    obs_t got, e;
    for (int k = 0; k < 4; k++) begin
      clr_in();
      case (k)
        0: begin
          ex_mem_read = 1'b1; ex_dst = 5'd0;
          id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
        end
        1: begin
          id_is_branch = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd0;
          mem_mem_read = 1'b1; mem_dst = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        end
        2: begin
          ex_mem_read = 1'b1; ex_dst = 5'd5; id_rs = 5'd5; id_rt = 5'd5;
        end
        default: begin
          ex_reg_write = 1'b1; ex_dst = 5'd6; mem_mem_read = 1'b1; mem_dst = 5'd6;
          id_rs = 5'd6; id_uses_rs = 1'b1;
        end
      endcase
      push_exp(3'b000, 3'b000, 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL r0_immunity cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_stretched_rs();
    obs_t got, e;
    logic [2:0] s_t [5] = '{3'b111, 3'b111, 3'b111, 3'b001, 3'b000};
    logic [2:0] a_t [5] = '{3'b000, 3'b011, 3'b011, 3'b001, 3'b000};
    for (int k = 0; k < 5; k++) begin
      clr_in();
      if (k < 3) begin
        ex_mem_read = 1'b1; ex_dst = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
      end
      push_exp(s_t[k], a_t[k], 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL stretched_rs cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_branch();
    obs_t got, e;
    logic [2:0] s_t [7] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000};
    logic [2:0] f_t [7] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
    for (int k = 0; k < 7; k++) begin
      clr_in();
      case (k)
        0, 2: begin
          id_is_branch = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd7;
          id_rs = 5'd7; id_uses_rs = 1'b1; id_branch_taken = (k == 2);
        end
        3: begin
          id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd7; id_uses_rs = 1'b1;
        end
        5: begin
          id_is_branch = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd3;
          id_rt = 5'd3; id_uses_rt = 1'b1;
        end
        default: ;
      endcase
      push_exp(s_t[k], 3'b000, f_t[k]);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL branch cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_branch_behind_load();
    obs_t got, e;
    logic [2:0] s_t [5] = '{3'b111, 3'b111, 3'b011, 3'b001, 3'b000};
    logic [2:0] a_t [5] = '{3'b000, 3'b011, 3'b011, 3'b001, 3'b000};
    logic [2:0] f_t [5] = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b000};
    for (int k = 0; k < 5; k++) begin
      clr_in();
      if (k == 0) begin
        id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd7;
        id_rs = 5'd7; id_uses_rs = 1'b1;
      end else if (k < 4) begin
        id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd7; id_uses_rs = 1'b1;
        if (k == 1) begin
          mem_mem_read = 1'b1; mem_dst = 5'd7;
        end
      end
      push_exp(s_t[k], a_t[k], f_t[k]);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL branch_behind_load cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t got, e;
    logic [2:0] s_t [5] = '{3'b111, 3'b011, 3'b000, 3'b000, 3'b000};
    logic [2:0] a_t [5] = '{3'b000, 3'b011, 3'b000, 3'b000, 3'b000};
    for (int k = 0; k < 5; k++) begin
      clr_in();
      rst = (k == 2);
      if (k == 0 || k == 2) begin
        ex_mem_read = 1'b1; ex_dst = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        id_branch_taken = (k == 2);
      end
      push_exp(s_t[k], a_t[k], 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_mid_stall cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    obs_t got, e;
    logic [2:0] s, a;
    for (int k = 0; k < 25; k++) begin
      clr_in();
      perf_clr = (k == 20);
      if (k <= 20) begin
        ex_mem_read = 1'b1; ex_dst = 5'd12; id_rs = 5'd12; id_uses_rs = 1'b1;
        s = 3'b111;
        a = {1'b0, (k % 3) != 0, (k % 4) != 0};
      end else if (k < 24) begin
        s = 3'b001; a = 3'b001;
      end else begin
        s = 3'b000; a = 3'b000;
      end
      push_exp(s, a, 3'b000);
      @(negedge clk); got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL saturation cyc%0d got %h want %h", k, got, e);
      end
      step();
    end
    perf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; perf_clr = 1'b0; clr_in();
    test_reset();
    test_load_use_rt();
    test_r0_immunity();
    test_stretched_rs();
    test_branch();
    test_branch_behind_load();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
